// File: rtl/tlc_vehicle_sensor.sv
// -----------------------------------------------------------------------------
// tlc_vehicle_sensor
//
// Front end for the country-road vehicle detector of the traffic light
// controller. The raw loop-detector signal is synchronised (two flops) and
// debounced. The result drives the controller's car-present request x. The
// controller's country-road light (ctrd) is watched to find out when a pending
// request has been served. The block also reports how long the current request
// has been waiting.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive identical synced samples needed to change the
//                     filtered presence (>= 1)
//   CNT_W           : width of wait_cnt; the count saturates at all-ones
//
// Ports
//   clk       in   1      system clock, rising edge
//   clr       in   1      synchronous active-high reset
//   loop_raw  in   1      raw loop-detector output (asynchronous, may glitch)
//   ctrd      in   2      country-road light: 0 RED, 1 YELLOW, 2 GREEN, 3 illegal
//   x         out  1      registered car-present request to the controller
//   served    out  1      one-cycle pulse when a pending request first sees GREEN
//   wait_cnt  out  CNT_W  cycles spent waiting in REQ, saturating
// -----------------------------------------------------------------------------
module tlc_vehicle_sensor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             loop_raw,
  input  logic [1:0]       ctrd,
  output logic             x,
  output logic             served,
  output logic [CNT_W-1:0] wait_cnt
);

  // The debounce counter only has to hold 0 .. DEBOUNCE_CYCLES-1. On the edge
  // where it would reach DEBOUNCE_CYCLES, filt takes the new value instead.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [1:0] LIGHT_RED   = 2'd0;
  localparam logic [1:0] LIGHT_GREEN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  logic            s1_r;
  logic            s2_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            filt_r;

  state_t          state_r;
  state_t          state_nxt_s;

  logic             x_r;
  logic             served_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             x_nxt_s;
  logic             served_nxt_s;
  logic [CNT_W-1:0] wait_cnt_nxt_s;

  logic is_green_s;
  logic is_red_s;

  // The illegal code 2'b11 matches neither GREEN nor RED, so it never causes a transition.
  assign is_green_s = (ctrd == LIGHT_GREEN);
  assign is_red_s   = (ctrd == LIGHT_RED);

  // Two-flop synchroniser for the asynchronous loop input.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= loop_raw;
      s2_r <= s1_r;
    end
  end

  // Debounce: filt follows s2 only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (clr) begin
      db_cnt_r <= {DB_W{1'b0}};
      filt_r   <= 1'b0;
    end else if (s2_r == filt_r) begin
      db_cnt_r <= {DB_W{1'b0}};
      filt_r   <= filt_r;
    end else if (db_cnt_r == DB_LAST) begin
      db_cnt_r <= {DB_W{1'b0}};
      filt_r   <= s2_r;
    end else begin
      db_cnt_r <= db_cnt_r + DB_W'(1);
      filt_r   <= filt_r;
    end
  end

  // State register together with the registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= ST_IDLE;
      x_r        <= 1'b0;
      served_r   <= 1'b0;
      wait_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      x_r        <= x_nxt_s;
      served_r   <= served_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next-state logic. Once REQ is reached, the request stays latched until GREEN is seen.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (filt_r) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (is_green_s) begin
          state_nxt_s = ST_SERVE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_SERVE: begin
        if (is_red_s && filt_r) begin
          state_nxt_s = ST_REQ;
        end else if (is_red_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SERVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of x, served and wait_cnt, based on the transition being taken.
  always_comb begin
    x_nxt_s        = 1'b0;
    served_nxt_s   = 1'b0;
    wait_cnt_nxt_s = wait_cnt_r;

    // In SERVE, x follows filt so green is extended while cars keep arriving.
    case (state_nxt_s)
      ST_IDLE:  x_nxt_s = 1'b0;
      ST_REQ:   x_nxt_s = 1'b1;
      ST_SERVE: x_nxt_s = filt_r;
      default:  x_nxt_s = 1'b0;
    endcase

    if ((state_r == ST_REQ) && (state_nxt_s == ST_SERVE)) begin
      served_nxt_s = 1'b1;
    end else begin
      served_nxt_s = 1'b0;
    end

    // A new request restarts the count. Every cycle spent in REQ counts, including the
    // one that leaves it. In IDLE and SERVE the count holds so it can be read after service.
    if ((state_r != ST_REQ) && (state_nxt_s == ST_REQ)) begin
      wait_cnt_nxt_s = CNT_ZERO;
    end else if ((state_r == ST_REQ) && (wait_cnt_r != CNT_MAX)) begin
      wait_cnt_nxt_s = wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
  end

  assign x        = x_r;
  assign served   = served_r;
  assign wait_cnt = wait_cnt_r;

endmodule
